// File: rtl/aes_128_key_expand.sv
// AES-128 key-schedule engine: expands a 128-bit cipher key into 11 round keys
// and streams them as 22 x 64-bit words (low half first) into the key RAM,
// then pulses key_ready. One expansion round takes 4 cycles and shares a
// 1-cycle-latency BRAM S-box through sbox_addr/sbox_data.
module aes_128_key_expand #(
  parameter int LENGTH_KEY_SET = 22,
  parameter int NUM_ROUNDS     = 10
) (
  input  logic         clk,
  input  logic         kill_n,
  input  logic         key_start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic [31:0]  sbox_addr,
  input  logic [31:0]  sbox_data,
  output logic [63:0]  ram_in,
  output logic         en_wr,
  output logic         key_ready
);

  // Each round key occupies exactly two RAM words; catch mismatched overrides.
  if (LENGTH_KEY_SET != 2 * (NUM_ROUNDS + 1)) begin : gLengthCheck
    $error("aes_128_key_expand: LENGTH_KEY_SET must equal 2*(NUM_ROUNDS+1)");
  end

  localparam logic [3:0] LastRound = 4'(NUM_ROUNDS);

  typedef enum logic [2:0] {
    IDLE,
    WR_LO,
    WR_HI,
    SUB,
    EXPAND,
    DONE
  } state_e;

  state_e       state_q;
  logic [127:0] roundKey_q;
  logic [7:0]   rcon_q;
  logic [3:0]   round_q;

  logic         busy_q;
  logic [31:0]  sboxAddr_q;
  logic [63:0]  ramIn_q;
  logic         enWr_q;
  logic         keyReady_q;

  logic [31:0]  temp_d;
  logic [31:0]  w0_d;
  logic [31:0]  w1_d;
  logic [31:0]  w2_d;
  logic [31:0]  w3_d;
  logic [127:0] nextKey_d;
  logic [7:0]   nextRcon_d;

  // One key-schedule round: chain the SubWord result through the four words, advance Rcon by xtime.
  always_comb begin
    temp_d     = sbox_data ^ {rcon_q, 24'h000000};
    w0_d       = roundKey_q[127:96] ^ temp_d;
    w1_d       = roundKey_q[95:64]  ^ w0_d;
    w2_d       = roundKey_q[63:32]  ^ w1_d;
    w3_d       = roundKey_q[31:0]   ^ w2_d;
    nextKey_d  = {w0_d, w1_d, w2_d, w3_d};
    nextRcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1B : 8'h00);
  end

  // Control FSM; all outputs are registered alongside the state they belong to.
  always_ff @(posedge clk or negedge kill_n) begin
    if (!kill_n) begin
      state_q    <= IDLE;
      roundKey_q <= '0;
      rcon_q     <= '0;
      round_q    <= '0;
      busy_q     <= 1'b0;
      sboxAddr_q <= '0;
      ramIn_q    <= '0;
      enWr_q     <= 1'b0;
      keyReady_q <= 1'b0;
    end else begin
      enWr_q     <= 1'b0;
      ramIn_q    <= '0;
      keyReady_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (key_start) begin
            roundKey_q <= key_in;
            rcon_q     <= 8'h01;
            round_q    <= '0;
            state_q    <= WR_LO;
            busy_q     <= 1'b1;
            enWr_q     <= 1'b1;
            ramIn_q    <= key_in[63:0];
          end
        end
        WR_LO: begin
          state_q <= WR_HI;
          enWr_q  <= 1'b1;
          ramIn_q <= roundKey_q[127:64];
        end
        WR_HI: begin
          if (round_q == LastRound) begin
            state_q    <= DONE;
            keyReady_q <= 1'b1;
          end else begin
            state_q    <= SUB;
            sboxAddr_q <= {roundKey_q[23:0], roundKey_q[31:24]};
          end
        end
        SUB: begin
          state_q <= EXPAND;
        end
        EXPAND: begin
          roundKey_q <= nextKey_d;
          rcon_q     <= nextRcon_d;
          round_q    <= round_q + 4'd1;
          state_q    <= WR_LO;
          enWr_q     <= 1'b1;
          ramIn_q    <= nextKey_d[63:0];
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign sbox_addr = sboxAddr_q;
  assign ram_in    = ramIn_q;
  assign en_wr     = enWr_q;
  assign key_ready = keyReady_q;

endmodule

// File: tb/tb_aes_128_key_expand.sv
// Testbench for aes_128_key_expand: behavioural 1-cycle S-box and a
// word-oriented FIPS-197 key-expansion reference model.
module tb_aes_128_key_expand;

  localparam int MAXC = 100;

  logic         clk = 1'b0;
  logic         kill_n = 1'b0;
  logic         key_start = 1'b0;
  logic [127:0] key_in = '0;
  logic         busy;
  logic [31:0]  sbox_addr;
  logic [31:0]  sbox_data;
  logic [63:0]  ram_in;
  logic         en_wr;
  logic         key_ready;

  int checks = 0;
  int errors = 0;

  logic [7:0]  sboxTab [256];
  logic [7:0]  rconTab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
  logic [63:0] expWords [22];
  logic [31:0] expSub [11];
  logic [63:0] expWordsA [22];

  logic        enWrLog  [MAXC];
  logic        busyLog  [MAXC];
  logic        readyLog [MAXC];
  logic [63:0] ramInLog [MAXC];
  logic [31:0] sboxLog  [MAXC];
  logic [63:0] wrQ [$];

  aes_128_key_expand #(.LENGTH_KEY_SET(22), .NUM_ROUNDS(10)) dut (
    .clk       (clk),
    .kill_n    (kill_n),
    .key_start (key_start),
    .key_in    (key_in),
    .busy      (busy),
    .sbox_addr (sbox_addr),
    .sbox_data (sbox_data),
    .ram_in    (ram_in),
    .en_wr     (en_wr),
    .key_ready (key_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    sbox_data <= {sboxTab[sbox_addr[31:24]], sboxTab[sbox_addr[23:16]],
                  sboxTab[sbox_addr[15:8]],  sboxTab[sbox_addr[7:0]]};

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  task automatic buildSbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      logic [7:0] xb;
      xb = 8'(x);
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (xb != 8'h00 && gmul(xb, 8'(y)) == 8'h01) inv = 8'(y);
      sboxTab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic buildModel(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i - 1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        expSub[i / 4] = t;
        t = {sboxTab[t[31:24]], sboxTab[t[23:16]], sboxTab[t[15:8]], sboxTab[t[7:0]]}
            ^ {rconTab[i / 4 - 1], 24'h000000};
      end
      w[i] = w[i - 4] ^ t;
    end
    for (int r = 0; r < 11; r++) begin
      expWords[2 * r]     = {w[4 * r + 2], w[4 * r + 3]};
      expWords[2 * r + 1] = {w[4 * r], w[4 * r + 1]};
    end
  endtask

  task automatic capture(input logic [127:0] key0, input int nCycles,
                         input int s1, input logic [127:0] k1,
                         input int s2, input logic [127:0] k2);
    wrQ.delete();
    for (int c = 0; c < MAXC; c++) begin
      enWrLog[c] = 1'b0; busyLog[c] = 1'b0; readyLog[c] = 1'b0;
      ramInLog[c] = '0; sboxLog[c] = '0;
    end
    @(negedge clk);
    key_start = 1'b1;
    key_in    = key0;
    for (int c = 1; c <= nCycles; c++) begin
      @(negedge clk);
      enWrLog[c]  = en_wr;
      busyLog[c]  = busy;
      readyLog[c] = key_ready;
      ramInLog[c] = ram_in;
      sboxLog[c]  = sbox_addr;
      if (en_wr === 1'b1) wrQ.push_back(ram_in);
      if (c == s1) begin
        key_start = 1'b1; key_in = k1;
      end else if (c == s2) begin
        key_start = 1'b1; key_in = k2;
      end else begin
        key_start = 1'b0;
      end
    end
    key_start = 1'b0;
  endtask

  task automatic test_reset();
    kill_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (en_wr !== 1'b0) begin errors++; $display("[TB] FAIL reset_en_wr: got %b expected 0", en_wr); end
    checks++; if (key_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_key_ready: got %b expected 0", key_ready); end
    checks++; if (ram_in !== 64'h0) begin errors++; $display("[TB] FAIL reset_ram_in: got %h expected 0", ram_in); end
    checks++; if (sbox_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_sbox_addr: got %h expected 0", sbox_addr); end
    kill_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_fips();
    logic [63:0] got;
    logic [63:0] ref64 [6];
    int          idx [6];
    logic        expEn;
    ref64 = '{64'habf7158809cf4f3c, 64'h2b7e151628aed2a6, 64'h23a339392a6c7605,
              64'ha0fafe1788542cb1, 64'he13f0cc8b6630ca6, 64'hd014f9a8c9ee2589};
    idx   = '{0, 1, 2, 3, 20, 21};
    buildModel(128'h2b7e151628aed2a6abf7158809cf4f3c);
    capture(128'h2b7e151628aed2a6abf7158809cf4f3c, 46, -1, '0, -1, '0);
    checks++;
    if (wrQ.size() != 22) begin errors++; $display("[TB] FAIL fips_write_count: got %0d expected 22", wrQ.size()); end
    for (int i = 0; i < 6; i++) begin
      got = (idx[i] < wrQ.size()) ? wrQ[idx[i]] : 'x;
      checks++;
      if (got !== ref64[i]) begin errors++; $display("[TB] FAIL fips_vector_w%0d: got %h expected %h", idx[i], got, ref64[i]); end
    end
    for (int i = 0; i < 22; i++) begin
      got = (i < wrQ.size()) ? wrQ[i] : 'x;
      checks++;
      if (got !== expWords[i]) begin errors++; $display("[TB] FAIL fips_model_w%0d: got %h expected %h", i, got, expWords[i]); end
    end
    for (int c = 1; c <= 46; c++) begin
      expEn = (c <= 42) && ((c % 4 == 1) || (c % 4 == 2));
      checks++;
      if (enWrLog[c] !== expEn) begin errors++; $display("[TB] FAIL fips_en_wr_c%0d: got %b expected %b", c, enWrLog[c], expEn); end
      checks++;
      if (busyLog[c] !== (c <= 43)) begin errors++; $display("[TB] FAIL fips_busy_c%0d: got %b expected %b", c, busyLog[c], c <= 43); end
      checks++;
      if (readyLog[c] !== (c == 43)) begin errors++; $display("[TB] FAIL fips_key_ready_c%0d: got %b expected %b", c, readyLog[c], c == 43); end
      if (!expEn) begin
        checks++;
        if (ramInLog[c] !== 64'h0) begin errors++; $display("[TB] FAIL fips_ram_in_idle_c%0d: got %h expected 0", c, ramInLog[c]); end
      end
    end
    for (int r = 1; r <= 10; r++) begin
      checks++;
      if (sboxLog[4 * r - 1] !== expSub[r]) begin errors++; $display("[TB] FAIL fips_sbox_addr_r%0d: got %h expected %h", r, sboxLog[4 * r - 1], expSub[r]); end
    end
  endtask

  task automatic test_zero_key();
    logic [63:0] got;
    capture('0, 46, -1, '0, -1, '0);
    got = (wrQ.size() > 2) ? wrQ[2] : 'x;
    checks++; if (got !== 64'h6263636362636363) begin errors++; $display("[TB] FAIL zero_r1_lo: got %h expected 6263636362636363", got); end
    got = (wrQ.size() > 3) ? wrQ[3] : 'x;
    checks++; if (got !== 64'h6263636362636363) begin errors++; $display("[TB] FAIL zero_r1_hi: got %h expected 6263636362636363", got); end
    got = (wrQ.size() > 20) ? wrQ[20] : 'x;
    checks++; if (got !== 64'h23e951cf6f8f188e) begin errors++; $display("[TB] FAIL zero_r10_lo: got %h expected 23e951cf6f8f188e", got); end
    got = (wrQ.size() > 21) ? wrQ[21] : 'x;
    checks++; if (got !== 64'hb4ef5bcb3e92e211) begin errors++; $display("[TB] FAIL zero_r10_hi: got %h expected b4ef5bcb3e92e211", got); end
  endtask

  task automatic test_random_keys();
    logic [127:0] key;
    logic [63:0]  got;
    for (int n = 0; n < 4; n++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      buildModel(key);
      capture(key, 46, -1, '0, -1, '0);
      checks++;
      if (wrQ.size() != 22) begin errors++; $display("[TB] FAIL rand%0d_write_count: got %0d expected 22", n, wrQ.size()); end
      for (int i = 0; i < 22; i++) begin
        got = (i < wrQ.size()) ? wrQ[i] : 'x;
        checks++;
        if (got !== expWords[i]) begin errors++; $display("[TB] FAIL rand%0d_w%0d: got %h expected %h", n, i, got, expWords[i]); end
      end
      checks++;
      if (readyLog[43] !== 1'b1) begin errors++; $display("[TB] FAIL rand%0d_key_ready: got %b expected 1", n, readyLog[43]); end
    end
  endtask

  task automatic test_ignore_start();
    logic [127:0] key;
    logic [63:0]  got;
    key = {$urandom, $urandom, $urandom, $urandom};
    buildModel(key);
    capture(key, 46, 10, {$urandom, $urandom, $urandom, $urandom}, 20, {$urandom, $urandom, $urandom, $urandom});
    checks++;
    if (wrQ.size() != 22) begin errors++; $display("[TB] FAIL ignore_write_count: got %0d expected 22", wrQ.size()); end
    for (int i = 0; i < 22; i++) begin
      got = (i < wrQ.size()) ? wrQ[i] : 'x;
      checks++;
      if (got !== expWords[i]) begin errors++; $display("[TB] FAIL ignore_w%0d: got %h expected %h", i, got, expWords[i]); end
    end
    checks++;
    if (readyLog[43] !== 1'b1) begin errors++; $display("[TB] FAIL ignore_key_ready: got %b expected 1", readyLog[43]); end
  endtask

  task automatic test_kill();
    logic [127:0] key;
    logic [63:0]  got;
    int           sawReady;
    int           sawWrite;
    key = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    key_start = 1'b1;
    key_in    = key;
    @(posedge clk);
    #1 key_start = 1'b0;
    repeat (16) @(posedge clk);
    #2;
    checks++; if (en_wr !== 1'b1) begin errors++; $display("[TB] FAIL kill_pre_en_wr: got %b expected 1", en_wr); end
    kill_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL kill_busy: got %b expected 0", busy); end
    checks++; if (en_wr !== 1'b0) begin errors++; $display("[TB] FAIL kill_en_wr: got %b expected 0", en_wr); end
    checks++; if (key_ready !== 1'b0) begin errors++; $display("[TB] FAIL kill_key_ready: got %b expected 0", key_ready); end
    checks++; if (ram_in !== 64'h0) begin errors++; $display("[TB] FAIL kill_ram_in: got %h expected 0", ram_in); end
    checks++; if (sbox_addr !== 32'h0) begin errors++; $display("[TB] FAIL kill_sbox_addr: got %h expected 0", sbox_addr); end
    @(negedge clk);
    @(negedge clk);
    kill_n = 1'b1;
    sawReady = 0;
    sawWrite = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (key_ready === 1'b1) sawReady++;
      if (en_wr === 1'b1) sawWrite++;
    end
    checks++; if (sawReady != 0) begin errors++; $display("[TB] FAIL kill_no_ready: got %0d expected 0", sawReady); end
    checks++; if (sawWrite != 0) begin errors++; $display("[TB] FAIL kill_no_write: got %0d expected 0", sawWrite); end
    buildModel(key);
    capture(key, 46, -1, '0, -1, '0);
    checks++;
    if (wrQ.size() != 22) begin errors++; $display("[TB] FAIL kill_restart_count: got %0d expected 22", wrQ.size()); end
    for (int i = 0; i < 22; i++) begin
      got = (i < wrQ.size()) ? wrQ[i] : 'x;
      checks++;
      if (got !== expWords[i]) begin errors++; $display("[TB] FAIL kill_restart_w%0d: got %h expected %h", i, got, expWords[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] keyA;
    logic [127:0] keyB;
    logic [63:0]  got;
    logic         expEn;
    int           cc;
    keyA = {$urandom, $urandom, $urandom, $urandom};
    keyB = {$urandom, $urandom, $urandom, $urandom};
    buildModel(keyA);
    for (int i = 0; i < 22; i++) expWordsA[i] = expWords[i];
    buildModel(keyB);
    capture(keyA, 90, 44, keyB, -1, '0);
    checks++;
    if (wrQ.size() != 44) begin errors++; $display("[TB] FAIL b2b_write_count: got %0d expected 44", wrQ.size()); end
    for (int i = 0; i < 44; i++) begin
      got = (i < wrQ.size()) ? wrQ[i] : 'x;
      checks++;
      if (i < 22) begin
        if (got !== expWordsA[i]) begin errors++; $display("[TB] FAIL b2b_a_w%0d: got %h expected %h", i, got, expWordsA[i]); end
      end else begin
        if (got !== expWords[i - 22]) begin errors++; $display("[TB] FAIL b2b_b_w%0d: got %h expected %h", i - 22, got, expWords[i - 22]); end
      end
    end
    for (int c = 1; c <= 90; c++) begin
      cc = (c > 44) ? c - 44 : c;
      expEn = (cc <= 42) && ((cc % 4 == 1) || (cc % 4 == 2));
      checks++;
      if (enWrLog[c] !== expEn) begin errors++; $display("[TB] FAIL b2b_en_wr_c%0d: got %b expected %b", c, enWrLog[c], expEn); end
      checks++;
      if (readyLog[c] !== (c == 43 || c == 87)) begin errors++; $display("[TB] FAIL b2b_key_ready_c%0d: got %b expected %b", c, readyLog[c], c == 43 || c == 87); end
    end
  endtask

  initial begin
    buildSbox();
    test_reset();
    test_fips();
    test_zero_key();
    test_random_keys();
    test_ignore_start();
    test_kill();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
